// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit types and debounce state encoding
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   // [0] ones, [1] tens, [2] hundreds; packs to the 12-bit display word
   typedef bcd_digit_t [2:0] bcd3_t;

   localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

   typedef enum logic [1:0] {
      IDLE,
      ARM_H,
      HIGH,
      ARM_L
   } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer plus debounce FSM, one press strobe per accepted rising edge
module btn_debounce #(
   parameter int DB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);
   import bcd_pkg::*;

   localparam int DB_W = $clog2(DB_CYCLES + 1);
   localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

   logic            sync_q1;
   logic            sync_q2;
   db_state_t       state;
   logic [DB_W-1:0] cnt;

   // bring the raw button into the clk domain before anything looks at it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= btn_raw;
         sync_q2 <= sync_q1;
      end
   end

   // level must stay stable for DB_CYCLES cycles in an ARM state before it is accepted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (sync_q2) state <= ARM_H;
            end
            ARM_H: begin
               if (!sync_q2) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= HIGH;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HIGH: begin
               cnt <= '0;
               if (!sync_q2) state <= ARM_L;
            end
            ARM_L: begin
               if (sync_q2) begin
                  state <= HIGH;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // strobe on the ARM_H->HIGH transition; the consumer registers it, keeping the edge-to-pulse latency at 2+DB_CYCLES+1
   assign press = (state == ARM_H) && sync_q2 && (cnt == CNT_LAST);

endmodule

// File: rtl/bcd_incr_ctl.sv
// rtl/bcd_incr_ctl.sv - debounced increment/clear buttons driving a 000-999 BCD counter with wrap strobe
module bcd_incr_ctl #(
   parameter int DB_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_inc,
   input  logic        btn_clr,
   output logic [11:0] bcd,
   output logic        inc_pulse,
   output logic        wrap
);
   import bcd_pkg::*;

   logic  inc_press;
   logic  clr_press;
   bcd3_t count_q;
   bcd3_t count_nx;
   logic  carry_out;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_inc),
      .press   (inc_press)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_clr),
      .press   (clr_press)
   );

   // ripple a decimal carry from ones through hundreds; carry out of hundreds means 999->000
   always_comb begin
      logic carry;
      count_nx = count_q;
      carry    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (carry) begin
            if (count_q[i] == BCD_MAX_DIGIT) begin
               count_nx[i] = 4'd0;
            end else begin
               count_nx[i] = count_q[i] + 1'b1;
               carry       = 1'b0;
            end
         end
      end
      carry_out = carry;
   end

   // whole-word update so no partially carried value is ever visible; clear overrides increment
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q   <= '0;
         inc_pulse <= 1'b0;
         wrap      <= 1'b0;
      end else if (clr_press) begin
         count_q   <= '0;
         inc_pulse <= 1'b0;
         wrap      <= 1'b0;
      end else if (inc_press) begin
         count_q   <= count_nx;
         inc_pulse <= 1'b1;
         wrap      <= carry_out;
      end else begin
         inc_pulse <= 1'b0;
         wrap      <= 1'b0;
      end
   end

   assign bcd = count_q;

endmodule

// File: tb/tb_bcd_incr_ctl.sv
// tb/tb_bcd_incr_ctl.sv - scoreboard bench for bcd_incr_ctl with randomized button bounce
module tb_bcd_incr_ctl;

   localparam int DB = 4;

   logic        clk;
   logic        rst;
   logic        btn_inc;
   logic        btn_clr;
   logic [11:0] bcd;
   logic        inc_pulse;
   logic        wrap;

   typedef struct {
      logic [11:0] bcd;
      logic        inc;
      logic        wrap;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   int          model_count;
   int          n_checks;
   int          n_errors;
   int          n_pulses;
   logic [11:0] prev_bcd;
   logic        prev_inc;

   bcd_incr_ctl #(.DB_CYCLES(DB)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_inc   (btn_inc),
      .btn_clr   (btn_clr),
      .bcd       (bcd),
      .inc_pulse (inc_pulse),
      .wrap      (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] to_bcd(input int v);
      logic [11:0] r;
      r[11:8] = 4'(v / 100);
      r[7:4]  = 4'((v / 10) % 10);
      r[3:0]  = 4'(v % 10);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // reference: plain decimal arithmetic on an integer count
   task automatic model_press(input bit do_inc, input bit do_clr);
      exp_t x;
      if (do_clr) begin
         if (model_count != 0) begin
            x.bcd = 12'h000; x.inc = 1'b0; x.wrap = 1'b0;
            exp_q.push_back(x);
         end
         model_count = 0;
      end else if (do_inc) begin
         x.wrap      = (model_count == 999);
         model_count = (model_count + 1) % 1000;
         x.bcd       = to_bcd(model_count);
         x.inc       = 1'b1;
         exp_q.push_back(x);
      end
   endtask

   task automatic drive(input bit do_inc, input bit do_clr, input logic v);
      btn_inc = do_inc ? v : 1'b0;
      btn_clr = do_clr ? v : 1'b0;
   endtask

   // bouncy press: short glitches, stable high, bouncy release, stable low
   task automatic press_btn(input bit do_inc, input bit do_clr);
      int nb;
      nb = $urandom_range(0, 2);
      repeat (nb) begin
         drive(do_inc, do_clr, 1'b1); cyc($urandom_range(1, 2));
         drive(do_inc, do_clr, 1'b0); cyc($urandom_range(1, 2));
      end
      model_press(do_inc, do_clr);
      drive(do_inc, do_clr, 1'b1); cyc(8 + $urandom_range(0, 3));
      nb = $urandom_range(0, 2);
      repeat (nb) begin
         drive(do_inc, do_clr, 1'b0); cyc($urandom_range(1, 2));
         drive(do_inc, do_clr, 1'b1); cyc($urandom_range(1, 2));
      end
      drive(do_inc, do_clr, 1'b0); cyc(9);
   endtask

   // monitor: any pulse or visible bcd change must match the next expected event
   always @(negedge clk) begin
      if (rst) begin
         if (prev_inc) begin
            n_checks++;
            if (inc_pulse || wrap) begin
               n_errors++;
               $display("FAIL pulse_width: inc_pulse=%0b wrap=%0b expected 0 0", inc_pulse, wrap);
            end
         end
         if (inc_pulse || bcd != prev_bcd) begin
            n_checks++;
            if (inc_pulse) n_pulses++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL unexpected_event: bcd=%03h inc_pulse=%0b wrap=%0b expected none", bcd, inc_pulse, wrap);
            end else begin
               e = exp_q.pop_front();
               if (bcd !== e.bcd || inc_pulse !== e.inc || wrap !== e.wrap) begin
                  n_errors++;
                  $display("FAIL scoreboard: bcd=%03h inc=%0b wrap=%0b expected bcd=%03h inc=%0b wrap=%0b",
                           bcd, inc_pulse, wrap, e.bcd, e.inc, e.wrap);
               end
            end
         end else if (wrap) begin
            n_checks++;
            n_errors++;
            $display("FAIL lone_wrap: wrap=1 expected 0 without inc_pulse");
         end
      end
      prev_bcd = bcd;
      prev_inc = inc_pulse && rst;
   end

   initial begin
      int lat;
      int p0;
      n_checks = 0; n_errors = 0; n_pulses = 0;
      model_count = 0; prev_bcd = 12'h000; prev_inc = 1'b0;
      rst = 1'b1; btn_inc = 1'b0; btn_clr = 1'b0;
      #3 rst = 1'b0;
      btn_inc = 1'b1;
      cyc(3);
      chk("reset_bcd", 32'(bcd), 32'h000);
      chk("reset_inc_pulse", 32'(inc_pulse), 32'h0);
      chk("reset_wrap", 32'(wrap), 32'h0);

      // button held through reset release: one press after 2+DB+1 cycles
      p0 = n_pulses;
      model_press(1'b1, 1'b0);
      rst = 1'b1;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (inc_pulse) begin
            lat = n;
            break;
         end
      end
      chk("press_latency", 32'(lat), 32'(2 + DB + 1));
      cyc(30);
      chk("held_single_press", 32'(n_pulses - p0), 32'd1);
      chk("first_bcd", 32'(bcd), 32'h001);
      btn_inc = 1'b0;
      cyc(10);

      // glitch shorter than DB
      p0 = n_pulses;
      btn_inc = 1'b1; cyc(3);
      btn_inc = 1'b0; cyc(20);
      chk("glitch_no_pulse", 32'(n_pulses - p0), 32'd0);
      chk("glitch_bcd", 32'(bcd), 32'h001);

      repeat (98) press_btn(1'b1, 1'b0);
      chk("bcd_099", 32'(bcd), 32'h099);
      press_btn(1'b1, 1'b0);
      chk("bcd_100", 32'(bcd), 32'h100);
      repeat (899) press_btn(1'b1, 1'b0);
      chk("bcd_999", 32'(bcd), 32'h999);
      press_btn(1'b1, 1'b0);
      chk("bcd_wrap_000", 32'(bcd), 32'h000);

      repeat (457) press_btn(1'b1, 1'b0);
      chk("bcd_457", 32'(bcd), 32'h457);
      p0 = n_pulses;
      drive(1'b1, 1'b1, 1'b1);
      model_press(1'b1, 1'b1);
      cyc(12);
      drive(1'b1, 1'b1, 1'b0);
      cyc(12);
      chk("prio_bcd", 32'(bcd), 32'h000);
      chk("prio_no_pulse", 32'(n_pulses - p0), 32'd0);

      repeat (123) press_btn(1'b1, 1'b0);
      chk("bcd_123", 32'(bcd), 32'h123);
      press_btn(1'b0, 1'b1);
      chk("clear_bcd", 32'(bcd), 32'h000);

      // async reset while the increment debouncer is arming
      repeat (42) press_btn(1'b1, 1'b0);
      chk("bcd_042", 32'(bcd), 32'h042);
      btn_inc = 1'b1;
      cyc(4);
      #2 rst = 1'b0;
      #1;
      chk("midreset_bcd", 32'(bcd), 32'h000);
      chk("midreset_inc_pulse", 32'(inc_pulse), 32'h0);
      exp_q.delete();
      model_count = 0;
      btn_inc = 1'b0;
      cyc(3);
      rst = 1'b1;
      p0 = n_pulses;
      cyc(30);
      chk("no_pending_press", 32'(n_pulses - p0), 32'd0);
      chk("post_reset_bcd", 32'(bcd), 32'h000);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
